// File: rtl/lbist_lfsr_gen.sv
// LBIST stimulus generator: emits N Galois-LFSR patterns to the CUT per start request, then a completion response.
// Optional LBIST_LFSR_CONTINUE_EN: the LFSR keeps its state across runs instead of reloading SEED on each start.
module lbist_lfsr_gen #(
    parameter int          PAT_BITS       = 32,
    parameter int          MAX_PATTERNS   = 32,
    parameter logic [31:0] SEED           = 32'h0000_0001,
    parameter logic [31:0] TAPS           = 32'h8020_0003,
    parameter int          LBIST_MSG_BITS = $clog2(MAX_PATTERNS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lbist_req_val,
    output logic                      lbist_req_rdy,
    input  logic [LBIST_MSG_BITS:0]   lbist_req_msg,
    output logic                      cut_req_val,
    output logic [PAT_BITS-1:0]       cut_req_msg,
    input  logic                      cut_req_rdy,
    output logic                      lbist_resp_val,
    output logic [LBIST_MSG_BITS:0]   lbist_resp_msg,
    input  logic                      lbist_resp_rdy,
    output logic [1:0]                dbg_state
);
    // Handshakes: a transfer happens on a rising clk edge where val && rdy are both 1;
    // once raised, val and msg hold until that transfer, and val never waits on rdy.

    localparam int CW = LBIST_MSG_BITS + 1;
    localparam logic [PAT_BITS-1:0] SEED_T   = PAT_BITS'(SEED);
    localparam logic [PAT_BITS-1:0] SEED_EFF = (SEED_T == '0) ? PAT_BITS'(1) : SEED_T;
    localparam logic [PAT_BITS-1:0] TAPS_T   = PAT_BITS'(TAPS);
    localparam logic [CW-1:0]       MAX_N    = CW'(MAX_PATTERNS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PAT_BITS-1:0] lfsr_q;
    logic [PAT_BITS-1:0] lfsr_next;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_inc;
    logic [CW-1:0]       n_q;
    logic [CW-1:0]       n_sat;
    logic                start_hs;
    logic                cut_hs;

    assign n_sat     = (lbist_req_msg > MAX_N) ? MAX_N : lbist_req_msg;
    assign count_inc = count_q + CW'(1);
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS_T : '0);
    assign start_hs  = (state_q == IDLE) && lbist_req_val;
    assign cut_hs    = (state_q == GEN) && cut_req_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            count_q <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            if (start_hs) begin
                n_q     <= n_sat;
                count_q <= '0;
`ifndef LBIST_LFSR_CONTINUE_EN
                lfsr_q  <= SEED_EFF;
`endif
            end else if (cut_hs) begin
                lfsr_q  <= lfsr_next;
                count_q <= count_inc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (lbist_req_val) state_d = (n_sat == '0) ? DONE : GEN;
            GEN:  if (cut_req_rdy && (count_inc == n_q)) state_d = DONE;
            DONE: if (lbist_resp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        lbist_req_rdy  = 1'b0;
        cut_req_val    = 1'b0;
        lbist_resp_val = 1'b0;
        case (state_q)
            IDLE:    lbist_req_rdy  = 1'b1;
            GEN:     cut_req_val    = 1'b1;
            DONE:    lbist_resp_val = 1'b1;
            default: lbist_req_rdy  = 1'b0;
        endcase
    end

    assign cut_req_msg    = lfsr_q;
    assign lbist_resp_msg = count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_lbist_lfsr_gen.sv
// Directed self-checking bench for lbist_lfsr_gen; expected patterns are hand-computed from x^32+x^22+x^2+x+1.
module tb_lbist_lfsr_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        lbist_req_val;
    logic        lbist_req_rdy;
    logic [5:0]  lbist_req_msg;
    logic        cut_req_val;
    logic [31:0] cut_req_msg;
    logic        cut_req_rdy;
    logic        lbist_resp_val;
    logic [5:0]  lbist_resp_msg;
    logic        lbist_resp_rdy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] P0 = 32'h0000_0001;
    localparam logic [31:0] P1 = 32'h8020_0003;
    localparam logic [31:0] P2 = 32'hC030_0002;
    localparam logic [31:0] P3 = 32'h6018_0001;

    lbist_lfsr_gen dut (
        .clk(clk), .reset(reset),
        .lbist_req_val(lbist_req_val), .lbist_req_rdy(lbist_req_rdy), .lbist_req_msg(lbist_req_msg),
        .cut_req_val(cut_req_val), .cut_req_msg(cut_req_msg), .cut_req_rdy(cut_req_rdy),
        .lbist_resp_val(lbist_resp_val), .lbist_resp_msg(lbist_resp_msg), .lbist_resp_rdy(lbist_resp_rdy),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Drivers
    task automatic start_run(input logic [5:0] n);
        lbist_req_val = 1'b1;
        lbist_req_msg = n;
        tick();
        lbist_req_val = 1'b0;
        lbist_req_msg = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        checks++; if (lbist_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got %b exp 1", lbist_req_rdy); end
        checks++; if (cut_req_val !== 1'b0) begin errors++; $display("FAIL reset_cut_val got %b exp 0", cut_req_val); end
        checks++; if (lbist_resp_val !== 1'b0) begin errors++; $display("FAIL reset_resp_val got %b exp 0", lbist_resp_val); end
        checks++; if (cut_req_msg !== P0) begin errors++; $display("FAIL reset_cut_msg got %h exp %h", cut_req_msg, P0); end
        checks++; if (lbist_resp_msg !== 6'd0) begin errors++; $display("FAIL reset_resp_msg got %0d exp 0", lbist_resp_msg); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_seq [3];
        exp_seq = '{P0, P1, P2};
        do_reset();
        cut_req_rdy = 1'b1;
        start_run(6'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (cut_req_val !== 1'b1 || cut_req_msg !== exp_seq[i]) begin
                errors++; $display("FAIL basic_pat%0d got val=%b msg=%h exp val=1 msg=%h", i, cut_req_val, cut_req_msg, exp_seq[i]);
            end
            tick();
        end
        checks++; if (lbist_resp_val !== 1'b1 || lbist_resp_msg !== 6'd3 || cut_req_val !== 1'b0) begin
            errors++; $display("FAIL basic_resp got val=%b msg=%0d cut_val=%b exp 1/3/0", lbist_resp_val, lbist_resp_msg, cut_req_val);
        end
        lbist_resp_rdy = 1'b1;
        tick();
        lbist_resp_rdy = 1'b0;
        checks++; if (lbist_req_rdy !== 1'b1 || lbist_resp_val !== 1'b0) begin
            errors++; $display("FAIL basic_back_idle got req_rdy=%b resp_val=%b exp 1/0", lbist_req_rdy, lbist_resp_val);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cut_req_rdy = 1'b1;
        start_run(6'd3);
        checks++; if (cut_req_msg !== P0) begin errors++; $display("FAIL stall_p0 got %h exp %h", cut_req_msg, P0); end
        tick();
        cut_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (cut_req_val !== 1'b1 || cut_req_msg !== P1) begin
                errors++; $display("FAIL stall_hold%0d got val=%b msg=%h exp val=1 msg=%h", i, cut_req_val, cut_req_msg, P1);
            end
        end
        cut_req_rdy = 1'b1;
        tick();
        checks++; if (cut_req_msg !== P2) begin errors++; $display("FAIL stall_p2 got %h exp %h", cut_req_msg, P2); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (lbist_resp_val !== 1'b1 || lbist_resp_msg !== 6'd3) begin
                errors++; $display("FAIL stall_resp_hold%0d got val=%b msg=%0d exp 1/3", i, lbist_resp_val, lbist_resp_msg);
            end
            tick();
        end
        lbist_resp_rdy = 1'b1;
        tick();
        lbist_resp_rdy = 1'b0;
        checks++; if (lbist_req_rdy !== 1'b1) begin errors++; $display("FAIL stall_idle got req_rdy=%b exp 1", lbist_req_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_first;
`ifdef LBIST_LFSR_CONTINUE_EN
        exp_first = P3;
`else
        exp_first = P0;
`endif
        do_reset();
        cut_req_rdy = 1'b1;
        lbist_resp_rdy = 1'b1;
        start_run(6'd3);
        tick(); tick(); tick();
        checks++; if (lbist_resp_val !== 1'b1) begin errors++; $display("FAIL b2b_resp1 got %b exp 1", lbist_resp_val); end
        tick();
        start_run(6'd3);
        checks++; if (cut_req_val !== 1'b1 || cut_req_msg !== exp_first) begin
            errors++; $display("FAIL b2b_run2_first got val=%b msg=%h exp val=1 msg=%h", cut_req_val, cut_req_msg, exp_first);
        end
        tick(); tick(); tick();
        checks++; if (lbist_resp_val !== 1'b1 || lbist_resp_msg !== 6'd3) begin
            errors++; $display("FAIL b2b_resp2 got val=%b msg=%0d exp 1/3", lbist_resp_val, lbist_resp_msg);
        end
        tick();
        lbist_resp_rdy = 1'b0;
    endtask

    task automatic test_zero_and_saturate();
        int hs;
        bit done;
        do_reset();
        cut_req_rdy = 1'b1;
        start_run(6'd0);
        checks++; if (cut_req_val !== 1'b0 || lbist_resp_val !== 1'b1 || lbist_resp_msg !== 6'd0) begin
            errors++; $display("FAIL zero_resp got cut_val=%b resp_val=%b msg=%0d exp 0/1/0", cut_req_val, lbist_resp_val, lbist_resp_msg);
        end
        lbist_resp_rdy = 1'b1;
        tick();
        lbist_resp_rdy = 1'b0;
        do_reset();
        start_run(6'd63);
        hs = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (lbist_resp_val) done = 1'b1;
            else begin
                if (cut_req_val && cut_req_rdy) hs++;
                tick();
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL sat_timeout got no resp exp resp within 200 cycles"); end
        checks++; if (hs != 32 || lbist_resp_msg !== 6'd32) begin
            errors++; $display("FAIL sat_count got hs=%0d msg=%0d exp 32/32", hs, lbist_resp_msg);
        end
        lbist_resp_rdy = 1'b1;
        tick();
        lbist_resp_rdy = 1'b0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        cut_req_rdy = 1'b1;
        start_run(6'd5);
        tick(); tick();
        checks++; if (cut_req_msg !== P2) begin errors++; $display("FAIL abort_p2 got %h exp %h", cut_req_msg, P2); end
        do_reset();
        checks++; if (dbg_state !== 2'd0 || cut_req_val !== 1'b0 || lbist_resp_val !== 1'b0 || lbist_req_rdy !== 1'b1) begin
            errors++; $display("FAIL abort_idle got st=%0d cut_val=%b resp_val=%b req_rdy=%b exp 0/0/0/1", dbg_state, cut_req_val, lbist_resp_val, lbist_req_rdy);
        end
        tick();
        checks++; if (lbist_resp_val !== 1'b0) begin errors++; $display("FAIL abort_noresp got %b exp 0", lbist_resp_val); end
        start_run(6'd1);
        checks++; if (cut_req_val !== 1'b1 || cut_req_msg !== P0) begin
            errors++; $display("FAIL abort_n1 got val=%b msg=%h exp val=1 msg=%h", cut_req_val, cut_req_msg, P0);
        end
        tick();
        checks++; if (lbist_resp_val !== 1'b1 || lbist_resp_msg !== 6'd1) begin
            errors++; $display("FAIL abort_n1_resp got val=%b msg=%0d exp 1/1", lbist_resp_val, lbist_resp_msg);
        end
        lbist_resp_rdy = 1'b1;
        tick();
        lbist_resp_rdy = 1'b0;
    endtask

    task automatic test_ignore_start();
        do_reset();
        cut_req_rdy = 1'b0;
        start_run(6'd3);
        lbist_req_val = 1'b1;
        lbist_req_msg = 6'd7;
        checks++; if (lbist_req_rdy !== 1'b0) begin errors++; $display("FAIL ign_gen_rdy got %b exp 0", lbist_req_rdy); end
        tick();
        checks++; if (dbg_state !== 2'd1 || cut_req_msg !== P0) begin
            errors++; $display("FAIL ign_gen_hold got st=%0d msg=%h exp 1/%h", dbg_state, cut_req_msg, P0);
        end
        cut_req_rdy = 1'b1;
        tick(); tick();
        checks++; if (cut_req_msg !== P2) begin errors++; $display("FAIL ign_p2 got %h exp %h", cut_req_msg, P2); end
        lbist_req_msg = 6'd2;
        tick();
        checks++; if (lbist_resp_val !== 1'b1 || lbist_resp_msg !== 6'd3 || lbist_req_rdy !== 1'b0) begin
            errors++; $display("FAIL ign_done got val=%b msg=%0d req_rdy=%b exp 1/3/0", lbist_resp_val, lbist_resp_msg, lbist_req_rdy);
        end
        tick();
        checks++; if (dbg_state !== 2'd2 || lbist_resp_msg !== 6'd3) begin
            errors++; $display("FAIL ign_done_hold got st=%0d msg=%0d exp 2/3", dbg_state, lbist_resp_msg);
        end
        lbist_req_val = 1'b0;
        lbist_req_msg = '0;
        lbist_resp_rdy = 1'b1;
        tick();
        lbist_resp_rdy = 1'b0;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL ign_idle got st=%0d exp 0", dbg_state); end
    endtask

    initial begin
        reset          = 1'b1;
        lbist_req_val  = 1'b0;
        lbist_req_msg  = '0;
        cut_req_rdy    = 1'b0;
        lbist_resp_rdy = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_zero_and_saturate();
        test_reset_abort();
        test_ignore_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
